// File: rtl/code_pkg.sv
// Shared constants for the code-lock front end: channel indices and debounce default.
package code_pkg;

   // Bit positions in the {S,R,G,B} level vector; R/G/B match the detector's colour triplets.
   localparam int unsigned CH_S = 3;
   localparam int unsigned CH_R = 2;
   localparam int unsigned CH_G = 1;
   localparam int unsigned CH_B = 0;

   localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 4;

   // True when at least two of the three colour bits are set.
   function automatic logic chord_hit(input logic [2:0] hits);
      return (hits[0] & hits[1]) | (hits[0] & hits[2]) | (hits[1] & hits[2]);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-FF synchronizer, hold-time debouncer and registered press pulse.
module debounce_channel
   import code_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic raw_i,
   output logic level_o,
   output logic pulse_o,
   output logic pulse_next_o
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pulse_q, pulse_d;

   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      pulse_d  = 1'b0;
      if (sync2_q == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         stable_d = sync2_q;
         cnt_d    = '0;
         pulse_d  = sync2_q;  // only a 0->1 acceptance is a press
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
         pulse_q  <= 1'b0;
      end else begin
         sync1_q  <= raw_i;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         pulse_q  <= pulse_d;
      end
   end

   assign level_o      = stable_q;
   assign pulse_o      = pulse_q;
   assign pulse_next_o = pulse_d;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the four raw lock buttons into clean press pulses and flags chorded colours.
module button_conditioner
   import code_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       SRaw,
   input  logic       RRaw,
   input  logic       GRaw,
   input  logic       BRaw,
   output logic       S,
   output logic       R,
   output logic       G,
   output logic       B,
   output logic [3:0] Level,
   output logic       ChordErr
);

   logic [3:0] raw_v;
   logic [3:0] level_v;
   logic [3:0] pulse_v;
   logic [3:0] pulse_next_v;
   logic       chord_q, chord_d;

   assign raw_v = {SRaw, RRaw, GRaw, BRaw};

   for (genvar i = 0; i < 4; i++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_ch (
         .clk_i       (Clk),
         .rst_i       (Rst),
         .raw_i       (raw_v[i]),
         .level_o     (level_v[i]),
         .pulse_o     (pulse_v[i]),
         .pulse_next_o(pulse_next_v[i])
      );
   end

   // Start is deliberately excluded: Start plus one colour is a legal combination.
   always_comb begin
      chord_d = chord_hit({pulse_next_v[CH_R], pulse_next_v[CH_G], pulse_next_v[CH_B]});
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         chord_q <= 1'b0;
      end else begin
         chord_q <= chord_d;
      end
   end

   assign S        = pulse_v[CH_S];
   assign R        = pulse_v[CH_R];
   assign G        = pulse_v[CH_G];
   assign B        = pulse_v[CH_B];
   assign Level    = level_v;
   assign ChordErr = chord_q;

endmodule
